// File: rtl/img_loader.sv
// img_loader: packs a stream of UART bytes into 24-bit words, MSB first, and
// writes one word per three accepted bytes into an image RAM until the frame
// (2**RAM_ADDR_BITS words) is full.
//
// Optional feature macro: IMG_LOADER_CHECKSUM_EN
//   When defined, every accepted frame byte is XOR-folded into a checksum.
//   After the last word the loader waits in CHECK for one more byte and
//   compares it against the checksum. The chk_err output holds the result.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; rx bytes ignored
// LOAD  | accepting bytes, writing one word per three bytes
// CHECK | frame written, waiting for the checksum byte (macro builds only)
// DONE  | frame complete; rx bytes ignored, start reloads from address 0
module img_loader #(
  parameter int RAM_WIDTH     = 24,
  parameter int RAM_ADDR_BITS = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     mem_we,
  output logic [RAM_ADDR_BITS-1:0] mem_addr,
  output logic [RAM_WIDTH-1:0]     mem_di,
  output logic                     busy,
  output logic                     done
`ifdef IMG_LOADER_CHECKSUM_EN
  ,
  output logic                     chk_err
`endif
);

`ifdef IMG_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;
`endif

  localparam logic [RAM_ADDR_BITS-1:0] LAST_ADDR = '1;

  state_t                   state;
  logic [1:0]               byte_cnt;
  logic [7:0]               byte0;
  logic [7:0]               byte1;
  logic [RAM_ADDR_BITS-1:0] word_addr;
`ifdef IMG_LOADER_CHECKSUM_EN
  logic [7:0]               checksum;
`endif

  // Loader FSM: byte packing, word writes and all registered outputs.
  // mem_addr/mem_di only change on a write, so they stay stable while
  // mem_we is low; word_addr is the internal next-write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      byte_cnt  <= 2'd0;
      byte0     <= 8'd0;
      byte1     <= 8'd0;
      word_addr <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_di    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef IMG_LOADER_CHECKSUM_EN
      checksum  <= 8'd0;
      chk_err   <= 1'b0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_LOAD;
            busy      <= 1'b1;
            done      <= 1'b0;
            byte_cnt  <= 2'd0;
            word_addr <= '0;
`ifdef IMG_LOADER_CHECKSUM_EN
            checksum  <= 8'd0;
            chk_err   <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (abort) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            byte_cnt <= 2'd0;
          end else if (rx_valid) begin
`ifdef IMG_LOADER_CHECKSUM_EN
            checksum <= checksum ^ rx_data;
`endif
            case (byte_cnt)
              2'd0: begin
                byte0    <= rx_data;
                byte_cnt <= 2'd1;
              end
              2'd1: begin
                byte1    <= rx_data;
                byte_cnt <= 2'd2;
              end
              default: begin
                mem_we   <= 1'b1;
                mem_addr <= word_addr;
                mem_di   <= {byte0, byte1, rx_data};
                byte_cnt <= 2'd0;
                if (word_addr == LAST_ADDR) begin
                  // last word: leave LOAD without wrapping the address
`ifdef IMG_LOADER_CHECKSUM_EN
                  state <= S_CHECK;
`else
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
`endif
                end else begin
                  word_addr <= word_addr + 1'b1;
                end
              end
            endcase
          end
        end
`ifdef IMG_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (rx_valid) begin
            chk_err <= (rx_data != checksum);
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
`endif
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/img_loader.md
IMG_LOADER -- requirements
Module: img_loader

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 24: image word width in bits; fixed at 24, packed as 3 bytes.
REQ-002 SHALL have parameter RAM_ADDR_BITS, default 10: image RAM address width; the frame is 2**RAM_ADDR_BITS words.
REQ-003 SHALL have port clk  in  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  in  1  one-cycle request to begin loading a frame.
REQ-006 SHALL have port abort  in  1  cancels an in-progress load.
REQ-007 SHALL have port rx_data  in  8  incoming byte (from UART receiver).
REQ-008 SHALL have port rx_valid  in  1  rx_data valid for this cycle; no backpressure.
REQ-009 SHALL have port mem_we  out  1  write strobe to the image RAM's write_enable.
REQ-010 SHALL have port mem_addr  out  RAM_ADDR_BITS  word address to the image RAM.
REQ-011 SHALL have port mem_di  out  RAM_WIDTH  write data to the image RAM.
REQ-012 SHALL have port busy  out  1  high while in LOAD (or CHECK).
REQ-013 SHALL have port done  out  1  high while in DONE.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, CHECK (macro-dependent), DONE.
REQ-015 SHALL move IDLE->LOAD or DONE->LOAD on start: clear byte counter to 0 and word address to 0.
REQ-016 SHALL ignore start in LOAD/CHECK.
REQ-017 SHALL, in LOAD, accept one byte per rx_valid cycle, with sustained back-to-back bytes every cycle supported.
REQ-018 SHALL pack bytes MSB first: byte0->[23:16], byte1->[15:8], byte2->[7:0].
REQ-019 SHALL, in the cycle after the third byte is accepted, assert mem_we for exactly one cycle with mem_addr = current word address and mem_di = the packed word; all outputs registered.
REQ-020 SHALL increment the word address after each write and reset the byte counter to 0.
REQ-021 SHALL, after the write to address 2**RAM_ADDR_BITS-1, go to DONE (or CHECK) without wrapping the address and with no further writes.
REQ-022 SHALL ignore rx_valid in IDLE and DONE.
REQ-023 SHALL, on abort in LOAD/CHECK: go to IDLE next cycle, discard any partial word, keep mem_we low; abort wins over a simultaneous rx_valid or third byte; abort in IDLE/DONE has no effect.
REQ-024 SHALL hold mem_addr and mem_di stable when mem_we is low.

Reset
REQ-025 SHALL, while rst_n is low: state=IDLE, mem_we=0, mem_addr=0, mem_di=0, busy=0, done=0, byte counter=0, checksum=0.
REQ-026 SHALL, on reset mid-load, drop the frame with no partial write issued; a fresh start is required.

Configuration
REQ-027 SHALL support macro IMG_LOADER_CHECKSUM_EN.
REQ-028 SHALL, with IMG_LOADER_CHECKSUM_EN defined: XOR all accepted frame bytes; after the last word, enter CHECK; the next rx_valid byte is compared to the XOR; add output chk_err (1 bit, reset 0), set to 1 on mismatch or 0 on match when entering DONE, and cleared on start.
REQ-029 SHALL, without IMG_LOADER_CHECKSUM_EN: no CHECK state, no chk_err port; the last write goes directly to DONE.

Verification
REQ-030 Bench SHALL cover: RAM_ADDR_BITS=2, start, bytes 01 02 03 every cycle -> mem_we one cycle after byte 03, addr 0, di 0x010203.
REQ-031 Bench SHALL cover: full 4-word frame, 12 bytes with gaps -> writes at addr 0,1,2,3 only, then done=1 and busy=0.
REQ-032 Bench SHALL cover: abort in the same cycle as the 3rd byte of word 1 -> no write at addr 1, IDLE, then start reloads from addr 0.
REQ-033 Bench SHALL cover: rst_n low after 5 bytes -> all outputs 0 at once, no write; rx bytes ignored until start.
REQ-034 Bench SHALL cover: start while busy, and rx_valid in DONE -> no state or address change.
REQ-035 Bench SHALL cover: with IMG_LOADER_CHECKSUM_EN, frame then correct XOR byte -> chk_err=0, done=1; wrong byte -> chk_err=1.
